// File: rtl/local_store_sequencer_pkg.sv
// Shared definitions for the local store sequencer: store-FSM control codes
// and the sequencer state encoding.
package local_store_sequencer_pkg;

    localparam logic [2:0] CODE_INIT      = 3'b000;
    localparam logic [2:0] CODE_HOLD      = 3'b001;
    localparam logic [2:0] CODE_INCR      = 3'b010;
    localparam logic [2:0] CODE_JUMP      = 3'b011;
    localparam logic [2:0] CODE_SET_K_ROW = 3'b100;
    localparam logic [2:0] CODE_SET_K_COL = 3'b101;
    localparam logic [2:0] CODE_SET_N_ROW = 3'b110;
    localparam logic [2:0] CODE_SET_N_COL = 3'b111;

    typedef enum logic [3:0] {
        S_IDLE  = 4'd0,
        S_SKR   = 4'd1,
        S_SKC   = 4'd2,
        S_SNR   = 4'd3,
        S_SNC   = 4'd4,
        S_INIT0 = 4'd5,
        S_LDK   = 4'd6,
        S_LDN   = 4'd7,
        S_INIT1 = 4'd8,
        S_CMP   = 4'd9,
        S_DONE  = 4'd10
    } state_e;

endpackage

// File: rtl/local_store_sequencer_seq_counter.sv
// Unsigned A-bit up-counter with synchronous clear (priority over enable)
// and a terminal-count compare against a limit input.
module seq_counter
    import local_store_sequencer_pkg::*;
#(
    parameter int A = 7
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         clr_i,
    input  logic         en_i,
    input  logic [A-1:0] lim_i,
    output logic         at_lim_o
);

    localparam logic [A-1:0] ONE = {{(A-1){1'b0}}, 1'b1};

    logic [A-1:0] cnt_q;
    logic [A-1:0] cnt_d;

    // Next count: clear wins over increment
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = {A{1'b0}};
        end else if (en_i) begin
            cnt_d = cnt_q + ONE;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= {A{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign at_lim_o = (cnt_q == lim_i);

endmodule

// File: rtl/local_store_sequencer.sv
// Per-PE sequencer driving the local store controller: programs offsets,
// loads kernel/neuron stores from a stream, then sweeps compute addresses.
module local_store_sequencer
    import local_store_sequencer_pkg::*;
#(
    parameter int depth  = 2,
    parameter int A      = 7,
    parameter int CTR_IP = 8
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              start,
    input  logic [depth-1:0]  cfgKRowOfst,
    input  logic [depth-1:0]  cfgKColOfst,
    input  logic [depth-1:0]  cfgNRowOfst,
    input  logic [depth-1:0]  cfgNColOfst,
    input  logic [A-1:0]      cfgKLen,
    input  logic [A-1:0]      cfgNLen,
    input  logic [A-1:0]      cfgOutRows,
    input  logic [A-1:0]      cfgOutCols,
    input  logic              inValid,
    output logic              inReady,
    output logic              loadTarget,
    input  logic              computeEn,
    output logic [CTR_IP-1:0] controlSignal,
    output logic [depth-1:0]  initSettings,
    output logic              macValid,
    output logic              busy,
    output logic              done
);

    localparam logic [A-1:0] ONE  = {{(A-1){1'b0}}, 1'b1};
    localparam logic [A-1:0] ZERO = {A{1'b0}};

    state_e           state_q, state_d;
    logic [depth-1:0] k_row_q, k_col_q, n_row_q, n_col_q;
    logic [A-1:0]     k_len_q, n_len_q, rows_q, cols_q;
    logic             row_end_q;

    logic [2:0]   k_ctrl_s, n_ctrl_s;
    logic         k_wr_s, n_wr_s;
    logic         ld_active_s, ld_last_s, ld_tc_s, c_last_s, r_last_s;
    logic         cmp_s, incr_s, jump_s, finish_s, sweep_s;
    logic [A-1:0] ld_lim_s;

    // State and job configuration capture
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= S_IDLE;
            k_row_q <= {depth{1'b0}};
            k_col_q <= {depth{1'b0}};
            n_row_q <= {depth{1'b0}};
            n_col_q <= {depth{1'b0}};
            k_len_q <= ZERO;
            n_len_q <= ZERO;
            rows_q  <= ZERO;
            cols_q  <= ZERO;
        end else begin
            state_q <= state_d;
            if (state_q == S_IDLE && start) begin
                k_row_q <= cfgKRowOfst;
                k_col_q <= cfgKColOfst;
                n_row_q <= cfgNRowOfst;
                n_col_q <= cfgNColOfst;
                k_len_q <= cfgKLen;
                n_len_q <= cfgNLen;
                rows_q  <= cfgOutRows;
                cols_q  <= cfgOutCols;
            end
        end
    end

    assign sweep_s     = (rows_q != ZERO) && (cols_q != ZERO);
    assign ld_active_s = (state_q == S_LDK) || (state_q == S_LDN);
    assign ld_lim_s    = (state_q == S_LDN) ? (n_len_q - ONE) : (k_len_q - ONE);
    assign ld_last_s   = ld_active_s && inValid && ld_tc_s;

    // row_end_q marks that the current row's columns are exhausted; the next
    // enabled sweep cycle is then a JUMP rather than an INCR.
    assign cmp_s    = (state_q == S_CMP);
    assign incr_s   = cmp_s && computeEn && !row_end_q;
    assign jump_s   = cmp_s && computeEn && row_end_q;
    assign finish_s = incr_s && c_last_s && r_last_s;

    seq_counter #(.A(A)) u_ld_cnt (
        .clk_i    (CLK),
        .rst_i    (RST),
        .clr_i    (!ld_active_s || ld_last_s),
        .en_i     (inValid),
        .lim_i    (ld_lim_s),
        .at_lim_o (ld_tc_s)
    );

    seq_counter #(.A(A)) u_col_cnt (
        .clk_i    (CLK),
        .rst_i    (RST),
        .clr_i    (!cmp_s || (incr_s && c_last_s)),
        .en_i     (incr_s),
        .lim_i    (cols_q - ONE),
        .at_lim_o (c_last_s)
    );

    seq_counter #(.A(A)) u_row_cnt (
        .clk_i    (CLK),
        .rst_i    (RST),
        .clr_i    (!cmp_s),
        .en_i     (jump_s),
        .lim_i    (rows_q - ONE),
        .at_lim_o (r_last_s)
    );

    // End-of-row flag for the sweep
    always_ff @(posedge CLK) begin
        if (RST) begin
            row_end_q <= 1'b0;
        end else if (!cmp_s || jump_s) begin
            row_end_q <= 1'b0;
        end else if (incr_s && c_last_s) begin
            row_end_q <= 1'b1;
        end else begin
            row_end_q <= row_end_q;
        end
    end

    // Next-state and combinational output decode
    always_comb begin
        state_d      = state_q;
        k_ctrl_s     = CODE_HOLD;
        n_ctrl_s     = CODE_HOLD;
        k_wr_s       = 1'b0;
        n_wr_s       = 1'b0;
        initSettings = {depth{1'b0}};
        inReady      = 1'b0;
        loadTarget   = 1'b0;
        macValid     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_SKR;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_SKR: begin
                k_ctrl_s     = CODE_SET_K_ROW;
                initSettings = k_row_q;
                state_d      = S_SKC;
            end
            S_SKC: begin
                k_ctrl_s     = CODE_SET_K_COL;
                initSettings = k_col_q;
                state_d      = S_SNR;
            end
            S_SNR: begin
                n_ctrl_s     = CODE_SET_N_ROW;
                initSettings = n_row_q;
                state_d      = S_SNC;
            end
            S_SNC: begin
                n_ctrl_s     = CODE_SET_N_COL;
                initSettings = n_col_q;
                state_d      = S_INIT0;
            end
            S_INIT0: begin
                k_ctrl_s = CODE_INIT;
                n_ctrl_s = CODE_INIT;
                if (k_len_q != ZERO) begin
                    state_d = S_LDK;
                end else if (n_len_q != ZERO) begin
                    state_d = S_LDN;
                end else if (sweep_s) begin
                    state_d = S_CMP;
                end else begin
                    state_d = S_DONE;
                end
            end
            S_LDK: begin
                inReady = 1'b1;
                if (inValid) begin
                    k_ctrl_s = CODE_INCR;
                    k_wr_s   = 1'b1;
                end else begin
                    k_ctrl_s = CODE_HOLD;
                end
                if (ld_last_s) begin
                    state_d = (n_len_q != ZERO) ? S_LDN : S_INIT1;
                end else begin
                    state_d = S_LDK;
                end
            end
            S_LDN: begin
                inReady    = 1'b1;
                loadTarget = 1'b1;
                if (inValid) begin
                    n_ctrl_s = CODE_INCR;
                    n_wr_s   = 1'b1;
                end else begin
                    n_ctrl_s = CODE_HOLD;
                end
                if (ld_last_s) begin
                    state_d = S_INIT1;
                end else begin
                    state_d = S_LDN;
                end
            end
            S_INIT1: begin
                k_ctrl_s = CODE_INIT;
                n_ctrl_s = CODE_INIT;
                state_d  = sweep_s ? S_CMP : S_DONE;
            end
            S_CMP: begin
                if (incr_s) begin
                    k_ctrl_s = CODE_INCR;
                    n_ctrl_s = CODE_INCR;
                    macValid = 1'b1;
                end else if (jump_s) begin
                    k_ctrl_s = CODE_JUMP;
                    n_ctrl_s = CODE_JUMP;
                end else begin
                    k_ctrl_s = CODE_HOLD;
                    n_ctrl_s = CODE_HOLD;
                end
                state_d = finish_s ? S_DONE : S_CMP;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign controlSignal = {k_ctrl_s, k_wr_s, n_ctrl_s, n_wr_s};
    assign busy          = (state_q != S_IDLE);
    assign done          = (state_q == S_DONE);

endmodule

// File: tb/tb_local_store_sequencer.sv
// Directed self-checking bench for local_store_sequencer; one task per scenario.
module tb_local_store_sequencer;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic       start = 1'b0;
    logic [1:0] cfgKRowOfst = 2'd0, cfgKColOfst = 2'd0, cfgNRowOfst = 2'd0, cfgNColOfst = 2'd0;
    logic [6:0] cfgKLen = 7'd0, cfgNLen = 7'd0, cfgOutRows = 7'd0, cfgOutCols = 7'd0;
    logic       inValid = 1'b0;
    logic       computeEn = 1'b0;
    logic       inReady, loadTarget, macValid, busy, done;
    logic [7:0] controlSignal;
    logic [1:0] initSettings;

    int checks   = 0;
    int failures = 0;

    always #5 CLK = ~CLK;

    local_store_sequencer #(.depth(2), .A(7), .CTR_IP(8)) dut (
        .CLK           (CLK),
        .RST           (RST),
        .start         (start),
        .cfgKRowOfst   (cfgKRowOfst),
        .cfgKColOfst   (cfgKColOfst),
        .cfgNRowOfst   (cfgNRowOfst),
        .cfgNColOfst   (cfgNColOfst),
        .cfgKLen       (cfgKLen),
        .cfgNLen       (cfgNLen),
        .cfgOutRows    (cfgOutRows),
        .cfgOutCols    (cfgOutCols),
        .inValid       (inValid),
        .inReady       (inReady),
        .loadTarget    (loadTarget),
        .computeEn     (computeEn),
        .controlSignal (controlSignal),
        .initSettings  (initSettings),
        .macValid      (macValid),
        .busy          (busy),
        .done          (done)
    );

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    // Pulse start for one cycle, then scramble cfg inputs to prove they were captured
    task automatic start_job(input logic [1:0] kr, input logic [1:0] kc, input logic [1:0] nr,
                             input logic [1:0] nc, input logic [6:0] kl, input logic [6:0] nl,
                             input logic [6:0] rows, input logic [6:0] cols);
        cfgKRowOfst = kr; cfgKColOfst = kc; cfgNRowOfst = nr; cfgNColOfst = nc;
        cfgKLen = kl; cfgNLen = nl; cfgOutRows = rows; cfgOutCols = cols;
        start = 1'b1;
        cyc();
        start = 1'b0;
        cfgKRowOfst = 2'd2; cfgKColOfst = 2'd1; cfgNRowOfst = 2'd1; cfgNColOfst = 2'd3;
        cfgKLen = 7'd9; cfgNLen = 7'd9; cfgOutRows = 7'd9; cfgOutCols = 7'd9;
    endtask

    task automatic test_reset();
        RST = 1'b1;
        cyc();
        cyc();
        RST = 1'b0;
        @(negedge CLK);
        checks++; if (controlSignal !== 8'h22) begin failures++; $display("FAIL reset_ctrl got=%h exp=22", controlSignal); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
        checks++; if (inReady !== 1'b0) begin failures++; $display("FAIL reset_inready got=%b exp=0", inReady); end
        checks++; if (macValid !== 1'b0) begin failures++; $display("FAIL reset_macvalid got=%b exp=0", macValid); end
        checks++; if (initSettings !== 2'd0) begin failures++; $display("FAIL reset_init got=%0d exp=0", initSettings); end
        checks++; if (loadTarget !== 1'b0) begin failures++; $display("FAIL reset_loadtarget got=%b exp=0", loadTarget); end
        cyc();
    endtask

    task automatic test_offsets();
        logic [7:0] ec [4];
        logic [1:0] ei [4];
        ec = '{8'h82, 8'hA2, 8'h2C, 8'h2E};
        ei = '{2'd1, 2'd2, 2'd3, 2'd0};
        start_job(2'd1, 2'd2, 2'd3, 2'd0, 7'd0, 7'd0, 7'd0, 7'd0);
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            checks++; if (controlSignal !== ec[i]) begin failures++; $display("FAIL set_ctrl[%0d] got=%h exp=%h", i, controlSignal, ec[i]); end
            checks++; if (initSettings !== ei[i]) begin failures++; $display("FAIL set_init[%0d] got=%0d exp=%0d", i, initSettings, ei[i]); end
            checks++; if (busy !== 1'b1) begin failures++; $display("FAIL set_busy[%0d] got=%b exp=1", i, busy); end
            cyc();
        end
        @(negedge CLK);
        checks++; if (controlSignal !== 8'h00) begin failures++; $display("FAIL init0_ctrl got=%h exp=00", controlSignal); end
        cyc();
        @(negedge CLK);
        checks++; if (done !== 1'b1) begin failures++; $display("FAIL offsets_done got=%b exp=1", done); end
        checks++; if (controlSignal !== 8'h22) begin failures++; $display("FAIL done_ctrl got=%h exp=22", controlSignal); end
        cyc();
    endtask

    task automatic test_gapped_load();
        logic [5:0] pat;
        pat = 6'b101101;
        start_job(2'd0, 2'd0, 2'd0, 2'd0, 7'd4, 7'd0, 7'd0, 7'd0);
        repeat (5) cyc();
        for (int i = 0; i < 6; i++) begin
            inValid = pat[i];
            @(negedge CLK);
            checks++; if (controlSignal !== (pat[i] ? 8'h52 : 8'h22)) begin failures++; $display("FAIL ldk_ctrl[%0d] got=%h exp=%h", i, controlSignal, pat[i] ? 8'h52 : 8'h22); end
            checks++; if (inReady !== 1'b1 || loadTarget !== 1'b0) begin failures++; $display("FAIL ldk_hs[%0d] got=%b%b exp=10", i, inReady, loadTarget); end
            cyc();
        end
        inValid = 1'b0;
        @(negedge CLK);
        checks++; if (controlSignal !== 8'h00 || inReady !== 1'b0) begin failures++; $display("FAIL ldk_init1 got=%h/%b exp=00/0", controlSignal, inReady); end
        cyc();
        @(negedge CLK);
        checks++; if (done !== 1'b1) begin failures++; $display("FAIL ldk_done got=%b exp=1", done); end
        cyc();
    endtask

    task automatic test_sweep();
        logic [7:0] ec [7];
        logic [6:0] mv;
        ec = '{8'h44, 8'h44, 8'h44, 8'h66, 8'h44, 8'h44, 8'h44};
        mv = 7'b1110111;
        start_job(2'd0, 2'd0, 2'd0, 2'd0, 7'd0, 7'd2, 7'd2, 7'd3);
        inValid = 1'b1;
        computeEn = 1'b1;
        repeat (5) cyc();
        for (int i = 0; i < 2; i++) begin
            @(negedge CLK);
            checks++; if (controlSignal !== 8'h25 || loadTarget !== 1'b1) begin failures++; $display("FAIL ldn[%0d] got=%h/%b exp=25/1", i, controlSignal, loadTarget); end
            cyc();
        end
        inValid = 1'b0;
        @(negedge CLK);
        checks++; if (controlSignal !== 8'h00) begin failures++; $display("FAIL sweep_init1 got=%h exp=00", controlSignal); end
        cyc();
        for (int i = 0; i < 7; i++) begin
            @(negedge CLK);
            checks++; if (controlSignal !== ec[i]) begin failures++; $display("FAIL sweep_ctrl[%0d] got=%h exp=%h", i, controlSignal, ec[i]); end
            checks++; if (macValid !== mv[6-i]) begin failures++; $display("FAIL sweep_mac[%0d] got=%b exp=%b", i, macValid, mv[6-i]); end
            checks++; if (done !== 1'b0) begin failures++; $display("FAIL sweep_early_done[%0d] got=%b exp=0", i, done); end
            cyc();
        end
        @(negedge CLK);
        checks++; if (done !== 1'b1 || controlSignal !== 8'h22) begin failures++; $display("FAIL sweep_done got=%b/%h exp=1/22", done, controlSignal); end
        cyc();
        computeEn = 1'b0;
    endtask

    task automatic test_stall_reset();
        logic [7:0] ec [9];
        logic [8:0] en;
        logic [8:0] mv;
        ec = '{8'h44, 8'h22, 8'h22, 8'h44, 8'h44, 8'h66, 8'h44, 8'h44, 8'h44};
        en = 9'b100111111;
        mv = 9'b100110111;
        start_job(2'd0, 2'd0, 2'd0, 2'd0, 7'd0, 7'd0, 7'd2, 7'd3);
        repeat (5) cyc();
        for (int i = 0; i < 9; i++) begin
            computeEn = en[8-i];
            @(negedge CLK);
            checks++; if (controlSignal !== ec[i]) begin failures++; $display("FAIL stall_ctrl[%0d] got=%h exp=%h", i, controlSignal, ec[i]); end
            checks++; if (macValid !== mv[8-i]) begin failures++; $display("FAIL stall_mac[%0d] got=%b exp=%b", i, macValid, mv[8-i]); end
            cyc();
        end
        computeEn = 1'b0;
        @(negedge CLK);
        checks++; if (done !== 1'b1) begin failures++; $display("FAIL stall_done got=%b exp=1", done); end
        cyc();
        start_job(2'd0, 2'd0, 2'd0, 2'd0, 7'd0, 7'd0, 7'd2, 7'd3);
        repeat (5) cyc();
        computeEn = 1'b1;
        cyc();
        cyc();
        RST = 1'b1;
        cyc();
        RST = 1'b0;
        computeEn = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            checks++; if (controlSignal !== 8'h22 || busy !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL midreset[%0d] got=%h/%b/%b exp=22/0/0", i, controlSignal, busy, done); end
            cyc();
        end
    endtask

    task automatic test_empty_job();
        int  lat;
        logic found;
        lat = 0;
        found = 1'b0;
        start_job(2'd0, 2'd0, 2'd0, 2'd0, 7'd0, 7'd0, 7'd0, 7'd0);
        for (int n = 1; n <= 20 && !found; n++) begin
            start = (n == 2) || (n == 3);
            @(negedge CLK);
            if (done === 1'b1) begin
                found = 1'b1;
                lat = n;
            end else begin
                cyc();
            end
        end
        checks++; if (found !== 1'b1) begin failures++; $display("FAIL empty_timeout got=no_done exp=done"); end
        checks++; if (lat != 6) begin failures++; $display("FAIL empty_latency got=%0d exp=6", lat); end
        start = 1'b1;
        cyc();
        start = 1'b0;
        @(negedge CLK);
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL empty_start_in_done got=%b exp=0", busy); end
        cyc();
        @(negedge CLK);
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL empty_idle got=%b/%b exp=0/0", busy, done); end
        cyc();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        #1;
        test_reset();
        test_offsets();
        test_gapped_load();
        test_sweep();
        test_stall_reset();
        test_empty_job();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
